iiitb_lifo_p: RTL and testbench

Parametrised successor to the team's 4-bit LIFO stack: a WIDTH-bit, DEPTH-entry last-in-first-out buffer. It adds the following behaviour:
- separate push and pop strobes, with same-cycle push+pop performed as a replace-top;
- an occupancy count and a programmable almost-full flag;
- a combinational top-of-stack peek;
- sticky overflow/underflow error flags.

It sits between a producer and a consumer in the same clock domain as a drop-in replacement where deeper or wider stacks, or error visibility, are needed.

---
 rtl/iiitb_lifo_p.sv | 108 ++++++++++
 tb/tb_iiitb_lifo_p.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/iiitb_lifo_p.sv
// rtl/iiitb_lifo_p.sv - parametrised LIFO stack with replace-top, almost-full and sticky error flags
module iiitb_lifo_p #(
    parameter  int WIDTH    = 4,
    parameter  int DEPTH    = 8,
    parameter  int AF_LEVEL = DEPTH - 1,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             EN,
    input  logic             Push,
    input  logic             Pop,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut,
    output logic [WIDTH-1:0] TOP,
    output logic [CW-1:0]    count,
    output logic             EMPTY,
    output logic             FULL,
    output logic             AFULL,
    output logic             OVF,
    output logic             UDF
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    sp_q, sp_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             we_d;
    logic [AW-1:0]    widx_d;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    push_idx;
    logic             empty, full;

    // Indices are only used when the matching full/empty guard allows it.
    assign top_idx  = AW'(sp_q - CW'(1));
    assign push_idx = AW'(sp_q);
    assign empty    = (sp_q == '0);
    assign full     = (sp_q == CW'(DEPTH));

    always_comb begin
        sp_d   = sp_q;
        dout_d = dout_q;
        ovf_d  = ovf_q;
        udf_d  = udf_q;
        we_d   = 1'b0;
        widx_d = push_idx;
        if (Rst) begin
            sp_d   = '0;
            dout_d = '0;
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
        end else if (EN) begin
            unique case ({Push, Pop})
                2'b10: begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        we_d = 1'b1;
                        sp_d = sp_q + CW'(1);
                    end
                end
                2'b01: begin
                    if (empty) begin
                        udf_d = 1'b1;
                    end else begin
                        dout_d = mem_q[top_idx];
                        sp_d   = sp_q - CW'(1);
                    end
                end
                2'b11: begin
                    // Empty stack: the pushed word passes straight through.
                    if (empty) begin
                        dout_d = dataIn;
                    end else begin
                        dout_d = mem_q[top_idx];
                        we_d   = 1'b1;
                        widx_d = top_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        sp_q   <= sp_d;
        dout_q <= dout_d;
        ovf_q  <= ovf_d;
        udf_q  <= udf_d;
    end

    always_ff @(posedge Clk) begin
        if (we_d) begin
            mem_q[widx_d] <= dataIn;
        end
    end

    assign dataOut = dout_q;
    assign TOP     = empty ? '0 : mem_q[top_idx];
    assign count   = sp_q;
    assign EMPTY   = empty;
    assign FULL    = full;
    assign AFULL   = (sp_q >= CW'(AF_LEVEL));
    assign OVF     = ovf_q;
    assign UDF     = udf_q;
endmodule

// File: tb/tb_iiitb_lifo_p.sv
// tb/tb_iiitb_lifo_p.sv - self-checking bench for iiitb_lifo_p (WIDTH=4, DEPTH=4, AF_LEVEL=3)
module tb_iiitb_lifo_p;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int AFL   = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             Clk = 1'b0;
    logic             Rst, EN, Push, Pop;
    logic [WIDTH-1:0] dataIn;
    logic [WIDTH-1:0] dataOut, TOP;
    logic [CW-1:0]    count;
    logic             EMPTY, FULL, AFULL, OVF, UDF;

    iiitb_lifo_p #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
        .Clk(Clk), .Rst(Rst), .EN(EN), .Push(Push), .Pop(Pop), .dataIn(dataIn),
        .dataOut(dataOut), .TOP(TOP), .count(count), .EMPTY(EMPTY), .FULL(FULL),
        .AFULL(AFULL), .OVF(OVF), .UDF(UDF)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       rst, en, push, pop;
        logic [3:0] din;
        logic [3:0] e_dout;
        int         e_cnt;
        logic [3:0] e_top;
        logic       e_ovf, e_udf;
    } vec_t;

    vec_t       vecs[$];
    int         n_chk  = 0;
    int         n_fail = 0;

    // Reference model: a queue whose back is the top of stack.
    logic [3:0] m_q[$];
    logic [3:0] m_dout;
    logic       m_ovf, m_udf;

    function automatic vec_t mk(logic rst, logic en, logic push, logic pop, logic [3:0] din,
                                logic [3:0] e_dout, int e_cnt, logic [3:0] e_top,
                                logic e_ovf, logic e_udf);
        vec_t v;
        v.rst = rst; v.en = en; v.push = push; v.pop = pop; v.din = din;
        v.e_dout = e_dout; v.e_cnt = e_cnt; v.e_top = e_top; v.e_ovf = e_ovf; v.e_udf = e_udf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_dout, input int e_cnt,
                             input logic [3:0] e_top, input logic e_ovf, input logic e_udf);
        chk({tag, ".dataOut"}, 32'(dataOut), 32'(e_dout));
        chk({tag, ".count"},   32'(count),   32'(e_cnt));
        chk({tag, ".TOP"},     32'(TOP),     32'(e_top));
        chk({tag, ".EMPTY"},   32'(EMPTY),   32'(e_cnt == 0));
        chk({tag, ".FULL"},    32'(FULL),    32'(e_cnt == DEPTH));
        chk({tag, ".AFULL"},   32'(AFULL),   32'(e_cnt >= AFL));
        chk({tag, ".OVF"},     32'(OVF),     32'(e_ovf));
        chk({tag, ".UDF"},     32'(UDF),     32'(e_udf));
    endtask

    function automatic void model_step(logic rst, logic en, logic push, logic pop, logic [3:0] din);
        if (rst) begin
            m_q.delete();
            m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
        end else if (en) begin
            if (push && !pop) begin
                if (m_q.size() == DEPTH) m_ovf = 1'b1;
                else m_q.push_back(din);
            end else if (pop && !push) begin
                if (m_q.size() == 0) m_udf = 1'b1;
                else m_dout = m_q.pop_back();
            end else if (push && pop) begin
                if (m_q.size() == 0) m_dout = din;
                else begin
                    m_dout = m_q[m_q.size() - 1];
                    m_q[m_q.size() - 1] = din;
                end
            end
        end
    endfunction

    task automatic cycle(input logic rst, input logic en, input logic push, input logic pop,
                         input logic [3:0] din);
        Rst = rst; EN = en; Push = push; Pop = pop; dataIn = din;
        @(posedge Clk);
        #1;
        model_step(rst, en, push, pop, din);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1; EN = 1'b0; Push = 1'b0; Pop = 1'b0; dataIn = '0;
        m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;

        // Reset held for two edges while the strobes and enable toggle
        cycle(1, 1, 1, 0, 4'h5);
        cycle(1, 0, 0, 1, 4'hA);
        check_all("reset", 4'h0, 0, 4'h0, 0, 0);

        //             rst en pu po din  dout cnt top ovf udf
        vecs.push_back(mk(0, 1, 1, 0, 4'h1, 4'h0, 1, 4'h1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'h3, 4'h0, 2, 4'h3, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'h5, 4'h0, 3, 4'h5, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'h7, 4'h0, 4, 4'h7, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'hF, 4'h0, 4, 4'h7, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 4'h0, 4'h7, 3, 4'h5, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 4'h0, 4'h5, 2, 4'h3, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 4'h0, 4'h3, 1, 4'h1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 4'h0, 4'h1, 0, 4'h0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 4'h0, 4'h1, 0, 4'h0, 1, 1));
        vecs.push_back(mk(1, 1, 1, 0, 4'h1, 4'h0, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'h2, 4'h0, 1, 4'h2, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'h4, 4'h0, 2, 4'h4, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 4'h9, 4'h4, 2, 4'h9, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'h1, 4'h4, 3, 4'h1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'h8, 4'h4, 4, 4'h8, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 4'h3, 4'h8, 4, 4'h3, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 4'h0, 4'h3, 3, 4'h1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 4'h0, 4'h1, 2, 4'h9, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 4'h0, 4'h9, 1, 4'h2, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 4'h0, 4'h2, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 4'hA, 4'hA, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'h6, 4'hA, 1, 4'h6, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 4'hF, 4'hA, 1, 4'h6, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 4'hF, 4'hA, 1, 4'h6, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 4'hF, 4'hA, 1, 4'h6, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 4'h0, 4'h6, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'h1, 4'h6, 1, 4'h1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'h2, 4'h6, 2, 4'h2, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'h3, 4'h6, 3, 4'h3, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 4'h4, 4'h0, 0, 4'h0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 4'h0, 4'h0, 0, 4'h0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst, vecs[i].en, vecs[i].push, vecs[i].pop, vecs[i].din);
            check_all($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_cnt, vecs[i].e_top,
                      vecs[i].e_ovf, vecs[i].e_udf);
        end

        // Fill to full, then hold Push+Pop for several cycles: replace-top only, never OVF
        cycle(1, 0, 0, 0, 4'h0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 1, 0, 4'(i + 1));
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 1, 4'(10 + i));
        check_all("full_replace", 4'hB, DEPTH, 4'hC, 0, 0);

        // Randomised traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) != 0),
                  1'($urandom), 1'($urandom), 4'($urandom));
            check_all($sformatf("rnd%0d", i), m_dout, m_q.size(),
                      (m_q.size() == 0) ? 4'h0 : m_q[m_q.size() - 1], m_ovf, m_udf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
